// File: rtl/serial_adder_deser_if.sv
// Bit-serial receive bus: LSB-first serial input with framing strobe, and
// the parallel word output with its valid and framing-error pulses.
interface serial_adder_deser_if #(
   parameter int WORDWIDTH = 8
);
   logic                 din;
   logic                 din_valid;
   logic                 sof;
   logic [WORDWIDTH-1:0] data_out;
   logic                 data_valid;
   logic                 frame_err;

   modport master (
      output din, din_valid, sof,
      input  data_out, data_valid, frame_err
   );

   modport slave (
      input  din, din_valid, sof,
      output data_out, data_valid, frame_err
   );
endinterface

// File: rtl/serial_adder_deser.sv
// Serial-in, parallel-out deserializer for the bit-serial CIC datapath:
// assembles LSB-first words framed by sof and flags words cut short.
module serial_adder_deser #(
   parameter int WORDWIDTH = 8
) (
   input logic                clk,
   input logic                rst_n,
   serial_adder_deser_if.slave bus
);
   localparam int                CNT_W = $clog2(WORDWIDTH);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WORDWIDTH - 1);
   localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   // Only the W-1 most recent bits need storing; the incoming bit completes the word.
   function automatic logic [WORDWIDTH-1:0] shift_in(
      input logic                 d,
      input logic [WORDWIDTH-2:0] s
   );
      return {d, s};
   endfunction

   state_t                state_p0, state_nxt;
   logic [CNT_W-1:0]      bit_cnt_p0, bit_cnt_nxt;
   logic [WORDWIDTH-2:0]  shreg_p0, shreg_nxt;
   logic [WORDWIDTH-1:0]  word_w;
   logic [WORDWIDTH-1:0]  data_out_p1, data_out_nxt;
   logic                  vld_p1, vld_nxt;
   logic                  frame_err_p1, frame_err_nxt;

   always_comb begin
      word_w        = shift_in(bus.din, shreg_p0);
      state_nxt     = state_p0;
      bit_cnt_nxt   = bit_cnt_p0;
      shreg_nxt     = shreg_p0;
      data_out_nxt  = data_out_p1;
      vld_nxt       = 1'b0;
      frame_err_nxt = 1'b0;
      case (state_p0)
         IDLE: begin
            if (bus.din_valid && bus.sof) begin
               shreg_nxt   = word_w[WORDWIDTH-1:1];
               bit_cnt_nxt = ONE;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.din_valid) begin
               shreg_nxt = word_w[WORDWIDTH-1:1];
               if (bus.sof) begin
                  frame_err_nxt = 1'b1;
                  bit_cnt_nxt   = ONE;
               end else if (bit_cnt_p0 == LAST) begin
                  data_out_nxt = word_w;
                  vld_nxt      = 1'b1;
                  bit_cnt_nxt  = '0;
                  state_nxt    = IDLE;
               end else begin
                  bit_cnt_nxt = bit_cnt_p0 + ONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: assembly state; stage p1: registered word and pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_p0     <= IDLE;
         bit_cnt_p0   <= '0;
         shreg_p0     <= '0;
         data_out_p1  <= '0;
         vld_p1       <= 1'b0;
         frame_err_p1 <= 1'b0;
      end else begin
         state_p0     <= state_nxt;
         bit_cnt_p0   <= bit_cnt_nxt;
         shreg_p0     <= shreg_nxt;
         data_out_p1  <= data_out_nxt;
         vld_p1       <= vld_nxt;
         frame_err_p1 <= frame_err_nxt;
      end
   end

   assign bus.data_out   = data_out_p1;
   assign bus.data_valid = vld_p1;
   assign bus.frame_err  = frame_err_p1;
endmodule

// File: tb/tb_serial_adder_deser.sv
// Bench for serial_adder_deser: directed framing scenarios followed by random
// traffic, each cycle compared against a bit-queue model of the framing rules.
module tb_serial_adder_deser;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   serial_adder_deser_if #(.WORDWIDTH(W)) bus ();

   serial_adder_deser #(.WORDWIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: the bits collected since the last accepted sof.
   bit         part_q[$];
   logic [W-1:0] exp_out;
   logic         exp_dv;
   logic         exp_fe;
   int           words_seen = 0;
   int           errs_seen  = 0;

   task automatic model_edge(input logic d, input logic v, input logic s, input logic r);
      logic [W-1:0] word;
      if (!r) begin
         part_q.delete();
         exp_out = '0;
         exp_dv  = 1'b0;
         exp_fe  = 1'b0;
         return;
      end
      exp_dv = 1'b0;
      exp_fe = 1'b0;
      if (!v) return;
      if (s) begin
         if (part_q.size() > 0) begin
            exp_fe = 1'b1;
            errs_seen++;
         end
         part_q.delete();
         part_q.push_back(d);
      end else if (part_q.size() > 0) begin
         part_q.push_back(d);
         if (part_q.size() == W) begin
            word = '0;
            for (int i = 0; i < W; i++) word = word + (W'(part_q[i]) << i);
            exp_out = word;
            exp_dv  = 1'b1;
            words_seen++;
            part_q.delete();
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input logic d, input logic v, input logic s, input logic r);
      bus.din       = d;
      bus.din_valid = v;
      bus.sof       = s;
      rst_n         = r;
      @(posedge clk);
      #1;
      model_edge(d, v, s, r);
      check("data_out",   32'(bus.data_out),   32'(exp_out));
      check("data_valid", 32'(bus.data_valid), 32'(exp_dv));
      check("frame_err",  32'(bus.frame_err),  32'(exp_fe));
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) step(w[i], 1'b1, i == 0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'($urandom), 1'b0, 1'($urandom), 1'b1);
   endtask

   initial begin
      logic [W-1:0] w;
      int           dv_count;
      int           fe_count;
      int           gap;

      exp_out = 'x;
      exp_dv  = 'x;
      exp_fe  = 'x;

      // Reset with random inputs on the lines
      for (int i = 0; i < 2; i++) step(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      idle(2);
      check("reset_out", 32'(bus.data_out), 32'h0);

      // Single word 0xA5
      send_word(8'hA5);
      check("a5_value", 32'(bus.data_out), 32'hA5);
      check("a5_valid", 32'(bus.data_valid), 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("a5_pulse_one_cycle", 32'(bus.data_valid), 32'h0);

      // Gapped word 0x3C: gaps after bit 2 and bit 5
      w = 8'h3C;
      dv_count = 0;
      fe_count = 0;
      for (int i = 0; i < W; i++) begin
         step(w[i], 1'b1, i == 0, 1'b1);
         dv_count += int'(bus.data_valid);
         fe_count += int'(bus.frame_err);
         gap = (i == 2) ? 3 : (i == 5) ? 1 : 0;
         for (int g = 0; g < gap; g++) begin
            step(1'($urandom), 1'b0, 1'($urandom), 1'b1);
            dv_count += int'(bus.data_valid);
            fe_count += int'(bus.frame_err);
         end
      end
      check("gap_value", 32'(bus.data_out), 32'h3C);
      check("gap_dv_count", 32'(dv_count), 32'd1);
      check("gap_fe_count", 32'(fe_count), 32'd0);
      idle(1);

      // Back-to-back 0xFF then 0x01 (spacing checked cycle by cycle by the model)
      send_word(8'hFF);
      check("b2b_first", 32'(bus.data_out), 32'hFF);
      send_word(8'h01);
      check("b2b_second", 32'(bus.data_out), 32'h01);
      idle(1);

      // Early sof: 4 bits of 0x55, then 0x81 starting with sof
      w = 8'h55;
      for (int i = 0; i < 4; i++) step(w[i], 1'b1, i == 0, 1'b1);
      w = 8'h81;
      step(w[0], 1'b1, 1'b1, 1'b1);
      check("early_sof_flag", 32'(bus.frame_err), 32'h1);
      check("early_sof_hold", 32'(bus.data_out), 32'h01);
      for (int i = 1; i < W; i++) step(w[i], 1'b1, 1'b0, 1'b1);
      check("early_sof_word", 32'(bus.data_out), 32'h81);
      idle(1);

      // Stray bits in IDLE, reset mid-word, then a full 0x0F
      for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1);
      w = 8'h0F;
      for (int i = 0; i < 3; i++) step(w[i], 1'b1, i == 0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("midreset_out", 32'(bus.data_out), 32'h0);
      send_word(8'h0F);
      check("post_reset_word", 32'(bus.data_out), 32'h0F);

      // Random traffic with occasional early sof, gaps and resets
      for (int n = 0; n < 1500; n++) begin
         step(1'($urandom),
              1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 10) == 0),
              1'($urandom_range(0, 299) != 0));
      end
      check("random_words_seen", 32'(words_seen > 20), 32'h1);
      check("random_errs_seen",  32'(errs_seen > 0),   32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timed out");
   end
endmodule
